// File: rtl/branch_stage_pkg.sv
// Shared defaults for the branch stage: packet field positions/widths and buffer sizing.
package branch_stage_pkg;

  localparam int PKT_W_DEF    = 38;
  localparam int DEST_LSB_DEF = 20;
  localparam int DEST_W_DEF   = 7;
  localparam int SEL_LSB_DEF  = 18;
  localparam int SEL_W_DEF    = 1;
  localparam int MF_BIT_DEF   = 19;

  localparam int FIFO_DEPTH = 2;

  // Occupancy of the two-entry buffer, 0..FIFO_DEPTH.
  typedef logic [1:0] cnt_t;

endpackage

// File: rtl/branch_stage_if.sv
// Packet handshake bundle: upstream offer/accept plus per-channel downstream offer/accept.
interface branch_stage_if
  import branch_stage_pkg::*;
#(
  parameter int PKT_W   = PKT_W_DEF,
  parameter int NUM_OUT = 2**SEL_W_DEF
);

  logic [PKT_W-1:0]   PACKET_IN;
  logic               SEND_IN;
  logic               ACK_OUT;
  logic [PKT_W-1:0]   PACKET_OUT;
  logic [NUM_OUT-1:0] SEND_OUT;
  logic [NUM_OUT-1:0] ACK_IN;

  modport slave  (input  PACKET_IN, SEND_IN, ACK_IN,
                  output ACK_OUT, PACKET_OUT, SEND_OUT);

  modport master (output PACKET_IN, SEND_IN, ACK_IN,
                  input  ACK_OUT, PACKET_OUT, SEND_OUT);

endinterface

// File: rtl/branch_fifo2.sv
// Two-entry in-order packet buffer; entry 0 is always the head, entry 1 the tail.
module branch_fifo2
  import branch_stage_pkg::*;
#(
  parameter int W = PKT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output cnt_t         count
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  cnt_t         cnt;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every branch sees pre-edge cnt/ent values.
    if (!rst_n) begin
      cnt  <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= wdata;
          else             ent1 <= wdata;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves ent0 untouched so the output holds.
          if (cnt == 2'd2) ent0 <= ent1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= wdata;
          end else begin
            ent0 <= ent1;
            ent1 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = ent0;
  assign count = cnt;

endmodule

// File: rtl/branch_stage_n.sv
// Branch stage: buffers packets, stamps the MF bit from a per-destination flag table,
// and offers the head packet to one of NUM_OUT channels. BRANCH_STAGE_TBL_WR_EN adds a writable table.
module branch_stage_n
  import branch_stage_pkg::*;
#(
  parameter int PKT_W    = PKT_W_DEF,
  parameter int DEST_LSB = DEST_LSB_DEF,
  parameter int DEST_W   = DEST_W_DEF,
  parameter int SEL_LSB  = SEL_LSB_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MF_BIT   = MF_BIT_DEF,
  parameter logic [2**DEST_W-1:0] TBL_INIT = '0
) (
  input logic              CP,
  input logic              MR_N,
`ifdef BRANCH_STAGE_TBL_WR_EN
  input logic              TBL_WE,
  input logic [DEST_W-1:0] TBL_WADDR,
  input logic              TBL_WDATA,
`endif
  branch_stage_if.slave    bus
);

  localparam int NUM_OUT = 2**SEL_W;
  localparam int TBL_D   = 2**DEST_W;

  logic [TBL_D-1:0]   tbl;
  logic [PKT_W-1:0]   merged;
  logic [PKT_W-1:0]   head;
  logic [NUM_OUT-1:0] send_out;
  cnt_t               count;
  logic               ack;
  logic               push;
  logic               pop;

`ifdef BRANCH_STAGE_TBL_WR_EN
  always_ff @(posedge CP) begin
    // NOTE: the table is plain flops, so reset reloads it like any other state.
    if (!MR_N)       tbl <= TBL_INIT;
    else if (TBL_WE) tbl[TBL_WADDR] <= TBL_WDATA;
  end
`else
  assign tbl = TBL_INIT;
`endif

  // Lookup reads the pre-edge table, so a same-cycle write is seen by the next packet.
  always_comb begin
    // NOTE: default assigned first so every path drives merged and no latch is inferred.
    merged         = bus.PACKET_IN;
    merged[MF_BIT] = tbl[bus.PACKET_IN[DEST_LSB +: DEST_W]];
  end

  assign ack  = MR_N & (count < 2'd2);
  assign push = bus.SEND_IN & ack;

  always_comb begin
    send_out = '0;
    if (count != 2'd0) send_out[head[SEL_LSB +: SEL_W]] = 1'b1;
  end

  // Only the selected channel's accept can pop; others are masked off by send_out.
  assign pop = |(send_out & bus.ACK_IN);

  branch_fifo2 #(.W(PKT_W)) u_fifo (
    .clk   (CP),
    .rst_n (MR_N),
    .push  (push),
    .wdata (merged),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign bus.ACK_OUT    = ack;
  assign bus.PACKET_OUT = head;
  assign bus.SEND_OUT   = send_out;

endmodule

// File: tb/tb_branch_stage_n.sv
// Directed bench for branch_stage_n with a queue-based reference model checked every cycle.
module tb_branch_stage_n;

  localparam int PKT_W    = 38;
  localparam int DEST_LSB = 20;
  localparam int DEST_W   = 7;
  localparam int SEL_LSB  = 18;
  localparam int MF_BIT   = 19;
  localparam int NUM_OUT  = 2;
  localparam logic [127:0] TBL_INIT = 128'h88;  // destinations 3 and 7 flagged

  typedef logic [PKT_W-1:0] pkt_t;

  logic clk  = 1'b0;
  logic mr_n = 1'b0;
  always #5 clk = ~clk;

  branch_stage_if #(.PKT_W(PKT_W), .NUM_OUT(NUM_OUT)) bus ();

`ifdef BRANCH_STAGE_TBL_WR_EN
  logic       tbl_we    = 1'b0;
  logic [6:0] tbl_waddr = '0;
  logic       tbl_wdata = 1'b0;
`endif

  branch_stage_n #(
    .PKT_W    (PKT_W),
    .DEST_LSB (DEST_LSB),
    .DEST_W   (DEST_W),
    .SEL_LSB  (SEL_LSB),
    .SEL_W    (1),
    .MF_BIT   (MF_BIT),
    .TBL_INIT (TBL_INIT)
  ) dut (
    .CP        (clk),
    .MR_N      (mr_n),
`ifdef BRANCH_STAGE_TBL_WR_EN
    .TBL_WE    (tbl_we),
    .TBL_WADDR (tbl_waddr),
    .TBL_WDATA (tbl_wdata),
`endif
    .bus       (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored packets plus the last emitted head.
  pkt_t         mq[$];
  pkt_t         m_last  = '0;
  logic [127:0] m_tbl   = TBL_INIT;
  bit           checking = 1'b0;
  bit           m_pop, m_push;
  pkt_t         m_ent;

  always @(posedge clk) begin
    if (!mr_n) begin
      mq.delete();
      m_last = '0;
      m_tbl  = TBL_INIT;
    end else begin
      m_pop  = (mq.size() > 0) && bus.ACK_IN[mq[0][SEL_LSB]];
      m_push = bus.SEND_IN && (mq.size() < 2);
      m_ent  = bus.PACKET_IN;
      m_ent[MF_BIT] = m_tbl[bus.PACKET_IN[DEST_LSB +: DEST_W]];
      if (m_pop)  m_last = mq.pop_front();
      if (m_push) mq.push_back(m_ent);
`ifdef BRANCH_STAGE_TBL_WR_EN
      if (tbl_we) m_tbl[tbl_waddr] = tbl_wdata;
`endif
    end
  end

  logic [1:0] e_send;
  pkt_t       e_pkt;
  logic       e_ack;

  always @(negedge clk) begin
    if (checking) begin
      e_ack  = mr_n && (mq.size() < 2);
      e_send = (mq.size() > 0) ? (2'b01 << mq[0][SEL_LSB]) : 2'b00;
      e_pkt  = (mq.size() > 0) ? mq[0] : m_last;
      check("model_ack_out",    64'(bus.ACK_OUT),    64'(e_ack));
      check("model_send_out",   64'(bus.SEND_OUT),   64'(e_send));
      check("model_packet_out", 64'(bus.PACKET_OUT), 64'(e_pkt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit send, input pkt_t p, input logic [1:0] ack);
    bus.SEND_IN   = send;
    bus.PACKET_IN = p;
    bus.ACK_IN    = ack;
  endtask

  initial begin
    drive(1'b0, '0, 2'b00);
    mr_n = 1'b0;
    cyc();
    cyc();
    checking = 1'b1;
    check("reset_ack_out",    64'(bus.ACK_OUT),    64'd0);
    check("reset_send_out",   64'(bus.SEND_OUT),   64'd0);
    check("reset_packet_out", 64'(bus.PACKET_OUT), 64'd0);
    mr_n = 1'b1;

    // dest=3 (flagged), sel=1: MF set, routed to channel 1.
    drive(1'b1, 38'h00_0034_1234, 2'b00);
    cyc();
    drive(1'b0, '0, 2'b00);
    check("first_send_out",   64'(bus.SEND_OUT),   64'h2);
    check("first_packet_out", 64'(bus.PACKET_OUT), 64'h3C_1234);
    bus.ACK_IN = 2'b01;
    cyc();
    check("unselected_ack_ignored", 64'(bus.SEND_OUT), 64'h2);
    bus.ACK_IN = 2'b10;
    cyc();
    check("empty_send_out",  64'(bus.SEND_OUT),   64'h0);
    check("hold_packet_out", 64'(bus.PACKET_OUT), 64'h3C_1234);

    // MF cleared for unflagged dest=1, set for flagged dest=7.
    drive(1'b1, 38'h00_0018_0055, 2'b01);
    cyc();
    check("mf_cleared", 64'(bus.PACKET_OUT), 64'h10_0055);
    drive(1'b1, 38'h00_0070_0002, 2'b01);
    cyc();
    check("mf_set_dest7", 64'(bus.PACKET_OUT), 64'h78_0002);
    drive(1'b0, '0, 2'b01);
    cyc();

    // Fill to two, third offer refused, then drain in order.
    drive(1'b1, 38'h11, 2'b00);
    cyc();
    check("one_held_ack", 64'(bus.ACK_OUT), 64'd1);
    drive(1'b1, 38'h22, 2'b00);
    cyc();
    check("full_ack_low", 64'(bus.ACK_OUT), 64'd0);
    drive(1'b1, 38'h33, 2'b00);
    cyc();
    check("full_head", 64'(bus.PACKET_OUT), 64'h11);
    drive(1'b0, '0, 2'b01);
    cyc();
    check("drain_second", 64'(bus.PACKET_OUT), 64'h22);
    check("drain_ack",    64'(bus.ACK_OUT),    64'd1);
    cyc();
    check("drained_send_out", 64'(bus.SEND_OUT),   64'h0);
    check("drained_hold",     64'(bus.PACKET_OUT), 64'h22);

    // Alternating channels at full rate.
    for (int k = 0; k < 6; k++) begin
      pkt_t p;
      p = pkt_t'(k + 'h100) | (pkt_t'(k & 1) << SEL_LSB);
      drive(1'b1, p, 2'b11);
      cyc();
      check("stream_send_out",   64'(bus.SEND_OUT),   (k & 1) ? 64'h2 : 64'h1);
      check("stream_packet_out", 64'(bus.PACKET_OUT), 64'(p));
      check("stream_ack_out",    64'(bus.ACK_OUT),    64'd1);
    end
    drive(1'b0, '0, 2'b11);
    cyc();

    // Blocked head on channel 0 holds back a channel-1 packet behind it.
    drive(1'b1, 38'h0A, 2'b10);
    cyc();
    drive(1'b1, 38'h0_4000B, 2'b10);
    cyc();
    drive(1'b0, '0, 2'b10);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("blocked_send_out",   64'(bus.SEND_OUT),   64'h1);
      check("blocked_packet_out", 64'(bus.PACKET_OUT), 64'h0A);
    end
    bus.ACK_IN = 2'b01;
    cyc();
    check("unblocked_send_out",   64'(bus.SEND_OUT),   64'h2);
    check("unblocked_packet_out", 64'(bus.PACKET_OUT), 64'h4_000B);
    bus.ACK_IN = 2'b10;
    cyc();
    check("unblocked_empty", 64'(bus.SEND_OUT), 64'h0);

`ifdef BRANCH_STAGE_TBL_WR_EN
    // Same-cycle write and lookup of dest 5 returns the old flag.
    drive(1'b1, 38'h50_0000, 2'b00);
    tbl_we = 1'b1; tbl_waddr = 7'd5; tbl_wdata = 1'b1;
    cyc();
    tbl_we = 1'b0;
    check("rbw_old_flag", 64'(bus.PACKET_OUT), 64'h50_0000);
    drive(1'b1, 38'h50_0001, 2'b01);
    cyc();
    check("rbw_new_flag", 64'(bus.PACKET_OUT), 64'h58_0001);
    drive(1'b0, '0, 2'b01);
    cyc();
`endif

    // Reset with two buffered packets discards them.
    drive(1'b1, 38'h77, 2'b00);
    cyc();
    drive(1'b1, 38'h66, 2'b00);
    cyc();
    check("pre_reset_full", 64'(bus.ACK_OUT), 64'd0);
    mr_n = 1'b0;
    drive(1'b1, 38'h55, 2'b11);
    cyc();
    check("mid_reset_send_out",   64'(bus.SEND_OUT),   64'h0);
    check("mid_reset_ack_out",    64'(bus.ACK_OUT),    64'd0);
    check("mid_reset_packet_out", 64'(bus.PACKET_OUT), 64'h0);
    cyc();
    check("held_reset_ack_out", 64'(bus.ACK_OUT), 64'd0);
    mr_n = 1'b1;
    drive(1'b0, '0, 2'b11);
    #1;
    check("release_ack_out", 64'(bus.ACK_OUT), 64'd1);
    cyc();
    check("release_send_out",   64'(bus.SEND_OUT),   64'h0);
    check("release_packet_out", 64'(bus.PACKET_OUT), 64'h0);
    cyc();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_stage_n.md
BRANCH_STAGE_N -- requirements
Module: branch_stage_n

Interface
REQ-001 Parameter PKT_W, default 38, meaning packet width in bits.
REQ-002 Parameter DEST_LSB, default 20, meaning LSB of the destination field.
REQ-003 Parameter DEST_W, default 7, meaning destination field width; table depth is 2**DEST_W.
REQ-004 Parameter SEL_LSB, default 18, meaning LSB of the branch-select field.
REQ-005 Parameter SEL_W, default 1, meaning select width; NUM_OUT = 2**SEL_W output channels.
REQ-006 Parameter MF_BIT, default 19, meaning packet bit overwritten by the table flag.
REQ-007 Parameter TBL_INIT, default all-zero, width 2**DEST_W, meaning the flag table contents after reset.
REQ-008 CP  in  1  clock, rising edge.
REQ-009 MR_N  in  1  reset; synchronous and active-low.
REQ-010 PACKET_IN  in  PKT_W  input packet.
REQ-011 SEND_IN  in  1  upstream offers PACKET_IN.
REQ-012 ACK_OUT  out  1  stage can accept this cycle.
REQ-013 PACKET_OUT  out  PKT_W  head packet with MF_BIT replaced.
REQ-014 SEND_OUT  out  NUM_OUT  one-hot offer to the selected channel.
REQ-015 ACK_IN  in  NUM_OUT  per-channel downstream accept.
REQ-016 TBL_WE / TBL_WADDR / TBL_WDATA  in  1 / DEST_W / 1  table write port; present only under REQ-033.

Function
REQ-017 Input transfer SHALL occur on a CP edge where SEND_IN=1 and ACK_OUT=1; output transfer on channel k where SEND_OUT[k]=1 and ACK_IN[k]=1.
REQ-018 Stage SHALL buffer up to 2 packets in FIFO order; occupancy counter 0..2.
REQ-019 ACK_OUT SHALL equal MR_N AND (count<2), with no combinational path from ACK_IN or SEND_IN.
REQ-020 On acceptance the stored entry SHALL be PACKET_IN with bit MF_BIT replaced by table[PACKET_IN[DEST_LSB+:DEST_W]], sampled in the accepting cycle.
REQ-021 When count>0, PACKET_OUT SHALL show the head entry and SEND_OUT SHALL be one-hot at index head[SEL_LSB+:SEL_W]; when count=0, SEND_OUT=0 and PACKET_OUT holds its last value.
REQ-022 Latency SHALL be 1 cycle: a packet accepted at edge N is offered from edge N onward (visible after N).
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve order; at count=2 no push occurs, so a pop yields count=1.
REQ-024 A blocked head SHALL block later packets regardless of their channel (no reordering).
REQ-025 Sustained throughput SHALL be one packet per cycle when the selected ACK_IN is held high.
REQ-026 ACK_IN bits of unselected channels SHALL be ignored.

Reset
REQ-027 On a CP edge with MR_N=0: count=0, both entries=0, SEND_OUT=0, PACKET_OUT=0.
REQ-028 While MR_N=0, ACK_OUT=0 and no transfer occurs on either side.
REQ-029 Reset SHALL discard buffered packets mid-operation without emitting them.
REQ-030 Table SHALL reload TBL_INIT on reset when REQ-033 is enabled.

Configuration
REQ-031 Macro BRANCH_STAGE_TBL_WR_EN SHALL select the table implementation.
REQ-032 Without it, table is constant TBL_INIT and TBL_WE/TBL_WADDR/TBL_WDATA ports are absent.
REQ-033 With it, table is a 2**DEST_W x 1 register array written at CP when TBL_WE=1 and MR_N=1.
REQ-034 Same-cycle write and lookup of one address SHALL return the old value (read-before-write).

Structure
REQ-035 Package branch_stage_pkg SHALL hold default field positions/widths and the packet-field constants.
REQ-036 Sub-module branch_fifo2 SHALL implement the 2-entry buffer and counter; the table and MF merge stay in the top.

Verification
REQ-037 Reset, then SEND_IN=1 with dest=3, SEL=1, TBL_INIT[3]=1 -> next cycle SEND_OUT=2'b10, PACKET_OUT[19]=1, other bits unchanged.
REQ-038 ACK_IN=0, three back-to-back packets -> two accepted, ACK_OUT=0 on third; ACK_IN[sel]=1 -> drains in order, ACK_OUT=1 after first pop.
REQ-039 Alternating SEL=0/1 stream, ACK_IN=2'b11 -> one packet per cycle, SEND_OUT alternates 01/10.
REQ-040 Head SEL=0 with ACK_IN=2'b10, second packet SEL=1 -> neither leaves until ACK_IN[0]=1.
REQ-041 With macro: write addr 5 data 1 same cycle as accepting dest=5 -> MF=old 0; next packet dest=5 -> MF=1.
REQ-042 MR_N=0 with count=2 -> next cycle SEND_OUT=0, ACK_OUT=0, PACKET_OUT=0; release -> ACK_OUT=1, nothing emitted.
